// File: rtl/clcd_ctrl.sv
// clcd_ctrl: character-LCD write sequencer.
// Takes one byte at a time from the host over a valid/ready handshake.
// Drives the HD44780 RS/RW/E/DQ pins with setup, enable-pulse, hold and
// execution-wait timing counted from clk.
// Build option: define CLCD_AUTOINIT_EN to compile in the 4-entry power-on
// init ROM (0x38, 0x0C, 0x01, 0x06) and the init_req rerun path. Without it,
// init_done rises as soon as the power-on wait ends and the host sends its
// own init bytes.
module clcd_ctrl #(
   parameter int PWR_WAIT_CYC = 2500000,
   parameter int SETUP_CYC    = 4,
   parameter int E_PULSE_CYC  = 25,
   parameter int HOLD_CYC     = 4,
   parameter int CMD_WAIT_CYC = 2500,
   parameter int CLR_WAIT_CYC = 100000
) (
   input  logic       clk,
   input  logic       nRESET,
   input  logic       cmd_valid,
   input  logic       cmd_rs,
   input  logic [7:0] cmd_data,
   output logic       cmd_ready,
   input  logic       init_req,
   output logic       init_done,
   output logic       busy,
   output logic       CLCD_RS,
   output logic       CLCD_RW,
   output logic       CLCD_E,
   output logic [7:0] CLCD_DQ
);

   typedef enum logic [2:0] {
      PWR_WAIT,
      INIT_LOAD,
      SETUP,
      EPULSE,
      HOLD,
      EXEC_WAIT,
      IDLE
   } state_t;

   localparam logic [21:0] PWR_LD   = 22'(PWR_WAIT_CYC);
   localparam logic [21:0] SETUP_LD = 22'(SETUP_CYC);
   localparam logic [21:0] EPULS_LD = 22'(E_PULSE_CYC);
   localparam logic [21:0] HOLD_LD  = 22'(HOLD_CYC);
   localparam logic [21:0] CMD_LD   = 22'(CMD_WAIT_CYC);
   localparam logic [21:0] CLR_LD   = 22'(CLR_WAIT_CYC);

   state_t      state_q, state_d;
   logic [21:0] cnt_q, cnt_d;
   logic        rs_q, rs_d;
   logic [7:0]  dq_q, dq_d;
   logic        initDone_q, initDone_d;
   logic        eStrobe_q, eStrobe_d;
   logic        cntDone;
   logic        longWait;

`ifdef CLCD_AUTOINIT_EN
   logic [1:0]  initIdx_q, initIdx_d;

   function automatic logic [7:0] romByte(input logic [1:0] idx);
      case (idx)
         2'd0:    romByte = 8'h38;
         2'd1:    romByte = 8'h0C;
         2'd2:    romByte = 8'h01;
         default: romByte = 8'h06;
      endcase
   endfunction
`endif

   // The counter holds the cycles left in the current timed state, so the
   // state ends on the cycle it reads 1.
   assign cntDone   = (cnt_q == 22'd1);
   // Clear (0x01) and home (0x02/0x03) need the long execution wait.
   assign longWait  = ~rs_q && (dq_q[7:2] == 6'd0) && (dq_q != 8'd0);
   assign cmd_ready = (state_q == IDLE) && initDone_q && ~init_req;
   assign init_done = initDone_q;
   assign busy      = (state_q != IDLE);
   assign CLCD_RS   = rs_q;
   assign CLCD_RW   = 1'b0;
   assign CLCD_E    = eStrobe_q;
   assign CLCD_DQ   = dq_q;

   // Next-state logic: step through the write cycle, load init bytes and accept host bytes.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rs_d       = rs_q;
      dq_d       = dq_q;
      initDone_d = initDone_q;
`ifdef CLCD_AUTOINIT_EN
      initIdx_d  = initIdx_q;
`endif
      case (state_q)
         PWR_WAIT: begin
            if (cntDone) begin
`ifdef CLCD_AUTOINIT_EN
               state_d    = INIT_LOAD;
               initIdx_d  = 2'd0;
`else
               state_d    = IDLE;
               initDone_d = 1'b1;
`endif
            end else begin
               cnt_d = cnt_q - 22'd1;
            end
         end
`ifdef CLCD_AUTOINIT_EN
         INIT_LOAD: begin
            dq_d      = romByte(initIdx_q);
            rs_d      = 1'b0;
            initIdx_d = initIdx_q + 2'd1;
            state_d   = SETUP;
            cnt_d     = SETUP_LD;
         end
`endif
         SETUP: begin
            if (cntDone) begin
               state_d = EPULSE;
               cnt_d   = EPULS_LD;
            end else begin
               cnt_d = cnt_q - 22'd1;
            end
         end
         EPULSE: begin
            if (cntDone) begin
               state_d = HOLD;
               cnt_d   = HOLD_LD;
            end else begin
               cnt_d = cnt_q - 22'd1;
            end
         end
         HOLD: begin
            if (cntDone) begin
               state_d = EXEC_WAIT;
               cnt_d   = longWait ? CLR_LD : CMD_LD;
            end else begin
               cnt_d = cnt_q - 22'd1;
            end
         end
         EXEC_WAIT: begin
            if (cntDone) begin
`ifdef CLCD_AUTOINIT_EN
               if (!initDone_q && (initIdx_q != 2'd0)) begin
                  state_d = INIT_LOAD;
               end else begin
                  state_d    = IDLE;
                  initDone_d = 1'b1;
               end
`else
               state_d = IDLE;
`endif
            end else begin
               cnt_d = cnt_q - 22'd1;
            end
         end
         IDLE: begin
            if (cmd_valid && cmd_ready) begin
               dq_d    = cmd_data;
               rs_d    = cmd_rs;
               state_d = SETUP;
               cnt_d   = SETUP_LD;
            end
`ifdef CLCD_AUTOINIT_EN
            else if (init_req) begin
               initDone_d = 1'b0;
               initIdx_d  = 2'd0;
               state_d    = INIT_LOAD;
            end
`endif
         end
         default: begin
            state_d = PWR_WAIT;
            cnt_d   = PWR_LD;
         end
      endcase
      eStrobe_d = (state_d == EPULSE);
   end

   // State and pin registers; reset drops E at once and restarts the power-on wait.
   always_ff @(posedge clk or negedge nRESET) begin
      if (!nRESET) begin
         state_q    <= PWR_WAIT;
         cnt_q      <= PWR_LD;
         rs_q       <= 1'b0;
         dq_q       <= 8'h00;
         initDone_q <= 1'b0;
         eStrobe_q  <= 1'b0;
`ifdef CLCD_AUTOINIT_EN
         initIdx_q  <= 2'd0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rs_q       <= rs_d;
         dq_q       <= dq_d;
         initDone_q <= initDone_d;
         eStrobe_q  <= eStrobe_d;
`ifdef CLCD_AUTOINIT_EN
         initIdx_q  <= initIdx_d;
`endif
      end
   end

endmodule

// File: tb/tb_clcd_ctrl.sv
// tb_clcd_ctrl: self-checking bench for clcd_ctrl with short timing parameters.
// Works with or without CLCD_AUTOINIT_EN; the model follows the same macro.
module tb_clcd_ctrl;

   localparam int PWR = 10;
   localparam int S   = 2;
   localparam int P   = 3;
   localparam int H   = 2;
   localparam int CMW = 5;
   localparam int CLW = 20;
   localparam int BIG = 1 << 30;
`ifdef CLCD_AUTOINIT_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif

   logic       clk;
   logic       nRESET;
   logic       cmd_valid;
   logic       cmd_rs;
   logic [7:0] cmd_data;
   logic       cmd_ready;
   logic       init_req;
   logic       init_done;
   logic       busy;
   logic       CLCD_RS;
   logic       CLCD_RW;
   logic       CLCD_E;
   logic [7:0] CLCD_DQ;

   int total = 0;
   int bad   = 0;

   // Model: edge count since reset release, and the timeline of the last write.
   int         e         = 0;
   int         freeAt    = PWR + 1;
   int         doneEdge  = AUTO ? BIG : PWR;
   int         lastStart = -1000;
   int         initLeft  = AUTO ? 4 : 0;
   logic [7:0] mDq       = 8'h00;
   logic       mRs       = 1'b0;
   logic [7:0] romExp [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};

   // Observed E pulses.
   int         riseCnt = 0;
   int         cnt55   = 0;
   logic       prevE   = 1'b0;
   logic [7:0] riseDq [$];
   int         riseEdge [$];

   clcd_ctrl #(
      .PWR_WAIT_CYC(PWR),
      .SETUP_CYC(S),
      .E_PULSE_CYC(P),
      .HOLD_CYC(H),
      .CMD_WAIT_CYC(CMW),
      .CLR_WAIT_CYC(CLW)
   ) dut (
      .clk(clk),
      .nRESET(nRESET),
      .cmd_valid(cmd_valid),
      .cmd_rs(cmd_rs),
      .cmd_data(cmd_data),
      .cmd_ready(cmd_ready),
      .init_req(init_req),
      .init_done(init_done),
      .busy(busy),
      .CLCD_RS(CLCD_RS),
      .CLCD_RW(CLCD_RW),
      .CLCD_E(CLCD_E),
      .CLCD_DQ(CLCD_DQ)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic modelReset();
      e         = 0;
      freeAt    = PWR + 1;
      doneEdge  = AUTO ? BIG : PWR;
      lastStart = -1000;
      initLeft  = AUTO ? 4 : 0;
      mDq       = 8'h00;
      mRs       = 1'b0;
   endtask

   task automatic modelLaunch(input logic rs, input logic [7:0] d);
      int w;
      lastStart = e;
      mDq       = d;
      mRs       = rs;
      w         = (!rs && d < 8'h04 && d != 8'h00) ? CLW : CMW;
      freeAt    = e + S + P + H + w + 1;
   endtask

   // Model update on each clock edge using the inputs held at that edge.
   initial begin
      forever begin
         @(posedge clk or negedge nRESET);
         if (!nRESET) begin
            modelReset();
         end else begin
            e++;
            if (e >= freeAt) begin
               if (initLeft > 0) begin
                  modelLaunch(1'b0, romExp[4 - initLeft]);
                  initLeft--;
                  if (initLeft == 0) doneEdge = freeAt - 1;
               end else if (init_req) begin
                  if (AUTO) begin
                     initLeft = 4;
                     doneEdge = BIG;
                     freeAt   = e + 1;
                  end
               end else if (cmd_valid && (e - 1 >= doneEdge)) begin
                  modelLaunch(cmd_rs, cmd_data);
               end
            end
         end
      end
   end

   // Compare process: every falling edge, DUT pins against the model.
   initial begin
      logic expBusy, expDone, expE, expReady;
      forever begin
         @(negedge clk);
         expBusy  = !(initLeft == 0 && e >= freeAt - 1);
         expDone  = (e >= doneEdge);
         expE     = (e - lastStart >= S) && (e - lastStart < S + P);
         expReady = !expBusy && expDone && !init_req;
         checkOutput("cycE", CLCD_E, expE);
         checkOutput("cycDQ", CLCD_DQ, mDq);
         checkOutput("cycRS", CLCD_RS, mRs);
         checkOutput("cycRW", CLCD_RW, 1'b0);
         checkOutput("cycBusy", busy, expBusy);
         checkOutput("cycInitDone", init_done, expDone);
         checkOutput("cycReady", cmd_ready, expReady);
         if (CLCD_E && !prevE) begin
            riseCnt++;
            riseDq.push_back(CLCD_DQ);
            riseEdge.push_back(e);
            if (CLCD_DQ == 8'h55) cnt55++;
         end
         prevE = CLCD_E;
      end
   end

   task automatic applyStimulus(input logic rs, input logic [7:0] d, output int edgeN);
      int waited = 0;
      bit ok = 1'b0;
      edgeN = -1;
      @(posedge clk);
      #2;
      cmd_valid = 1'b1;
      cmd_rs    = rs;
      cmd_data  = d;
      while (!ok && waited < 2000) begin
         @(negedge clk);
         waited++;
         if (cmd_ready) ok = 1'b1;
      end
      checkOutput("xferAccepted", ok, 1'b1);
      if (ok) begin
         @(posedge clk);
         #1;
         edgeN = e;
         #1;
      end
      cmd_valid = 1'b0;
   endtask

   task automatic waitIdle(output int idleEdge);
      int waited = 0;
      bit ok = 1'b0;
      while (!ok && waited < 3000) begin
         @(negedge clk);
         waited++;
         if (!busy && init_done) ok = 1'b1;
      end
      checkOutput("idleReached", ok, 1'b1);
      idleEdge = e;
   endtask

   initial begin
      int n, n1, n2, idleE, doneE, r0, c0, waited;
      bit ok;
      nRESET    = 1'b1;
      cmd_valid = 1'b0;
      cmd_rs    = 1'b0;
      cmd_data  = 8'h00;
      init_req  = 1'b0;

      #3 nRESET = 1'b0;
      #1;
      checkOutput("rstE", CLCD_E, 1'b0);
      checkOutput("rstDQ", CLCD_DQ, 8'h00);
      checkOutput("rstRS", CLCD_RS, 1'b0);
      checkOutput("rstBusy", busy, 1'b1);
      checkOutput("rstInitDone", init_done, 1'b0);
      checkOutput("rstReady", cmd_ready, 1'b0);
      repeat (2) @(posedge clk);
      #2 nRESET = 1'b1;

      // Power-on wait, then the init sequence when compiled in.
      waitIdle(doneE);
      checkOutput("initDoneEdge", doneE, AUTO ? 77 : 10);
      checkOutput("initRises", riseCnt, AUTO ? 4 : 0);
`ifdef CLCD_AUTOINIT_EN
      checkOutput("rom0", riseDq[0], 8'h38);
      checkOutput("rom1", riseDq[1], 8'h0C);
      checkOutput("rom2", riseDq[2], 8'h01);
      checkOutput("rom3", riseDq[3], 8'h06);
      checkOutput("gapShort", riseEdge[1] - riseEdge[0], 13);
      checkOutput("gapClear", riseEdge[3] - riseEdge[2], 28);
`endif

      // Single data byte: exact pin timeline relative to the transfer edge.
      applyStimulus(1'b1, 8'h41, n);
      for (int k = 0; k <= 12; k++) begin
         @(negedge clk);
         if (k == 0) begin
            checkOutput("patDQ", CLCD_DQ, 8'h41);
            checkOutput("patRS", CLCD_RS, 1'b1);
         end
         checkOutput("patE", CLCD_E, (k >= 2 && k <= 4));
         checkOutput("patReady", cmd_ready, (k == 12));
      end

      // Home command gets the long wait, the data byte after it the short one.
      applyStimulus(1'b0, 8'h02, n1);
      applyStimulus(1'b1, 8'h41, n2);
      checkOutput("homeSpacing", n2 - n1, 28);
      waitIdle(idleE);
      checkOutput("dataBusyLen", idleE - n2, 12);

      // Byte held while busy is written exactly once.
      r0 = riseCnt;
      c0 = cnt55;
      applyStimulus(1'b1, 8'h41, n);
      applyStimulus(1'b1, 8'h55, n);
      waitIdle(idleE);
      checkOutput("heldRises", riseCnt - r0, 2);
      checkOutput("held55Once", cnt55 - c0, 1);

      // init_req together with cmd_valid: request wins, byte follows once.
      r0 = riseCnt;
      c0 = cnt55;
      @(posedge clk);
      #2;
      init_req  = 1'b1;
      cmd_valid = 1'b1;
      cmd_rs    = 1'b1;
      cmd_data  = 8'h55;
      @(negedge clk);
      checkOutput("reqReady", cmd_ready, 1'b0);
      @(posedge clk);
      #2 init_req = 1'b0;
      @(negedge clk);
      checkOutput("reqInitDone", init_done, !AUTO);
      waited = 0;
      while (!cmd_ready && waited < 2000) begin
         @(negedge clk);
         waited++;
      end
      checkOutput("reqAccepted", cmd_ready, 1'b1);
      @(posedge clk);
      #2 cmd_valid = 1'b0;
      waitIdle(idleE);
      checkOutput("reqRises", riseCnt - r0, AUTO ? 5 : 1);
      checkOutput("req55Once", cnt55 - c0, 1);

      // Reset in the middle of the enable pulse.
      applyStimulus(1'b1, 8'hAA, n);
      ok = 1'b0;
      waited = 0;
      while (!ok && waited < 50) begin
         @(negedge clk);
         waited++;
         if (CLCD_E) ok = 1'b1;
      end
      checkOutput("eSeen", ok, 1'b1);
      #2 nRESET = 1'b0;
      #1;
      checkOutput("midRstE", CLCD_E, 1'b0);
      checkOutput("midRstDQ", CLCD_DQ, 8'h00);
      checkOutput("midRstInitDone", init_done, 1'b0);
      checkOutput("midRstBusy", busy, 1'b1);
      @(posedge clk);
      #2 nRESET = 1'b1;
      waitIdle(doneE);
      checkOutput("reInitDoneEdge", doneE, AUTO ? 77 : 10);

      applyStimulus(1'b1, 8'h33, n);
      waitIdle(idleE);
      repeat (3) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
